alu_issue_stage: RTL

ALU_ISSUE_STAGE -- requirements
Module: alu_issue_stage

---
 rtl/alu_issue_stage.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/alu_issue_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_issue_stage
// Description : Decodes MIPS instructions into ALU control/operands and
//               buffers them in an output register plus a skid register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_issue_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        ex_ready,
    output logic        out_valid,
    output logic [1:0]  alu_op,
    output logic [5:0]  operation,
    output logic [4:0]  sa,
    output logic [31:0] operando_1,
    output logic [31:0] operando_2,
    output logic        illegal
);

    typedef struct packed {
        logic [1:0]  alu_op;
        logic [5:0]  operation;
        logic [4:0]  sa;
        logic [31:0] op1;
        logic [31:0] op2;
        logic        illegal;
    } entry_t;

    localparam logic [1:0] c_ALUOP_ADD = 2'b00;
    localparam logic [1:0] c_ALUOP_SUB = 2'b01;
    localparam logic [1:0] c_ALUOP_OPR = 2'b10;
    localparam logic [1:0] c_ALUOP_INV = 2'b11;

    function automatic entry_t decode(input logic [31:0] ins,
                                      input logic [31:0] rs,
                                      input logic [31:0] rt);
        entry_t      d;
        logic [5:0]  opc;
        logic [5:0]  fn;
        logic [31:0] sext;
        logic [31:0] zext;
        opc  = ins[31:26];
        fn   = ins[5:0];
        sext = {{16{ins[15]}}, ins[15:0]};
        zext = {16'h0000, ins[15:0]};
        d    = '0;
        if (opc == 6'b000000) begin
            d.alu_op    = c_ALUOP_OPR;
            d.operation = fn;
            d.sa        = ins[10:6];
            d.op1       = rs;
            d.op2       = rt;
            case (fn)
                6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                6'b000111, 6'b100000, 6'b100001, 6'b100010, 6'b100011,
                6'b100100, 6'b100101, 6'b100110, 6'b100111, 6'b101010,
                6'b101011: d.illegal = 1'b0;
                default:   d.illegal = 1'b1;
            endcase
        end else if (opc == 6'b100011 || opc == 6'b101011) begin
            d.alu_op    = c_ALUOP_ADD;
            d.operation = 6'b100000;
            d.op1       = rs;
            d.op2       = sext;
        end else if (opc == 6'b000100 || opc == 6'b000101) begin
            d.alu_op    = c_ALUOP_SUB;
            d.operation = 6'b100010;
            d.op1       = rs;
            d.op2       = rt;
        end else if (opc[5:3] == 3'b001) begin
            // Logical immediates (ANDI..LUI range) zero-extend, arithmetic ones sign-extend
            d.alu_op    = c_ALUOP_OPR;
            d.operation = opc;
            d.op1       = rs;
            d.op2       = opc[2] ? zext : sext;
        end else begin
            d.alu_op    = c_ALUOP_INV;
            d.operation = 6'b111111;
            d.illegal   = 1'b1;
        end
        return d;
    endfunction

    entry_t w_dec;
    entry_t r_out;
    entry_t r_skid;
    logic   r_out_valid;
    logic   r_skid_valid;
    logic   w_in_fire;
    logic   w_out_fire;

    always_comb begin
        w_dec = decode(instr, rs_data, rt_data);
    end

    assign w_in_fire  = in_valid && !r_skid_valid;
    assign w_out_fire = r_out_valid && ex_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out        <= '0;
            r_skid       <= '0;
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid  <= 1'b0;
            r_skid_valid <= 1'b0;
        end else if (!r_out_valid || w_out_fire) begin
            // Output slot free this cycle: the skid entry is older, so it goes first
            if (r_skid_valid) begin
                r_out        <= r_skid;
                r_out_valid  <= 1'b1;
                r_skid_valid <= 1'b0;
            end else if (w_in_fire) begin
                r_out        <= w_dec;
                r_out_valid  <= 1'b1;
            end else begin
                r_out_valid  <= 1'b0;
            end
        end else if (w_in_fire) begin
            r_skid       <= w_dec;
            r_skid_valid <= 1'b1;
        end
    end

    assign in_ready   = !r_skid_valid;
    assign out_valid  = r_out_valid;
    assign alu_op     = r_out.alu_op;
    assign operation  = r_out.operation;
    assign sa         = r_out.sa;
    assign operando_1 = r_out.op1;
    assign operando_2 = r_out.op2;
    assign illegal    = r_out.illegal;

    logic w_unused;
    assign w_unused = ^instr[25:16];

endmodule
`default_nettype wire
